// File: rtl/ab_burst_sequencer_pkg.sv
// Shared types and defaults for the A/B burst sequencer.
// Default timing constants are reused by the A/B assertion benches.
package ab_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN_A,
        RUN_AB,
        GAP
    } state_t;

    localparam int A_LEN_DEF   = 5;
    localparam int B_AFTER_DEF = 4;
    localparam int GAP_LEN_DEF = 2;

    // Width that holds the longest phase without wrapping.
    function automatic int cnt_w(input int a_len, input int gap_len);
        int m;
        m = (a_len > gap_len) ? a_len : gap_len;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/ab_burst_sequencer_if.sv
// Control and A/B output bundle of the burst sequencer.
// master drives requests, slave is the sequencer itself.
interface ab_burst_sequencer_if #(
    parameter int BURST_W = 4
);
    logic               start;
    logic               abort;
    logic [BURST_W-1:0] n_bursts;
    logic               a_out;
    logic               b_out;
    logic               busy;
    logic               done;
    logic               aborted;
    logic [BURST_W-1:0] burst_idx;

    modport master (
        output start, abort, n_bursts,
        input  a_out, b_out, busy, done, aborted, burst_idx
    );

    modport slave (
        input  start, abort, n_bursts,
        output a_out, b_out, busy, done, aborted, burst_idx
    );
endinterface

// File: rtl/ab_seq_cnt.sv
// Loadable down-counter with zero flag.
// Saturates at zero so it can never wrap.
module ab_seq_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);
    logic [W-1:0] cnt;

    // Load has priority; decrement stops at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/ab_burst_sequencer.sv
// A/B burst sequencer: A for A_LEN cycles, B joins after B_AFTER,
// then a GAP_LEN idle gap; repeated for the latched burst count.
module ab_burst_sequencer
    import ab_seq_pkg::*;
#(
    parameter int A_LEN   = A_LEN_DEF,
    parameter int B_AFTER = B_AFTER_DEF,
    parameter int GAP_LEN = GAP_LEN_DEF,
    parameter int BURST_W = 4
) (
    input logic                clk,
    input logic                rst_n,
    ab_burst_sequencer_if.slave bus
);
    localparam int CW = cnt_w(A_LEN, GAP_LEN);
    localparam logic [CW-1:0] RA_LD  = CW'(B_AFTER - 1);
    localparam logic [CW-1:0] RAB_LD = CW'(A_LEN - B_AFTER - 1);
    localparam logic [CW-1:0] GAP_LD = CW'(GAP_LEN - 1);

    if (A_LEN < 2 || A_LEN > 255) begin : g_bad_alen
        $error("A_LEN out of range 2..255");
    end
    if (B_AFTER < 1 || B_AFTER >= A_LEN) begin : g_bad_bafter
        $error("B_AFTER out of range 1..A_LEN-1");
    end
    if (GAP_LEN < 1 || GAP_LEN > 255) begin : g_bad_gap
        $error("GAP_LEN out of range 1..255");
    end

    state_t             state, state_n;
    logic               ab_flag, ab_flag_n;
    logic               cyc_load, cyc_zero;
    logic [CW-1:0]      cyc_val;
    logic               bst_load, bst_dec, bst_zero;
    logic [BURST_W-1:0] bst_val;
    logic               done_n, abp_n;
    logic               idx_clr, idx_inc;

    ab_seq_cnt #(.W(CW)) u_cyc (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cyc_load),
        .load_val (cyc_val),
        .dec      (1'b1),
        .zero     (cyc_zero)
    );

    ab_seq_cnt #(.W(BURST_W)) u_bst (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (bst_load),
        .load_val (bst_val),
        .dec      (bst_dec),
        .zero     (bst_zero)
    );

    // State and sticky abort flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ab_flag <= 1'b0;
        end else begin
            state   <= state_n;
            ab_flag <= ab_flag_n;
        end
    end

    // Next state, counter reloads and pulse requests.
    always_comb begin
        state_n   = state;
        ab_flag_n = ab_flag;
        cyc_load  = 1'b0;
        cyc_val   = '0;
        bst_load  = 1'b0;
        bst_dec   = 1'b0;
        bst_val   = (bus.n_bursts == '0) ? '0 : bus.n_bursts - BURST_W'(1);
        done_n    = 1'b0;
        abp_n     = 1'b0;
        idx_clr   = 1'b0;
        idx_inc   = 1'b0;
        unique case (state)
            IDLE: begin
                ab_flag_n = 1'b0;
                if (bus.start && !bus.abort) begin
                    state_n  = RUN_A;
                    cyc_load = 1'b1;
                    cyc_val  = RA_LD;
                    bst_load = 1'b1;
                    idx_clr  = 1'b1;
                end
            end
            RUN_A, RUN_AB: begin
                if (bus.abort) begin
                    state_n   = GAP;
                    cyc_load  = 1'b1;
                    cyc_val   = GAP_LD;
                    ab_flag_n = 1'b1;
                    abp_n     = 1'b1;
                end else if (cyc_zero) begin
                    cyc_load = 1'b1;
                    if (state == RUN_A) begin
                        state_n = RUN_AB;
                        cyc_val = RAB_LD;
                    end else begin
                        state_n = GAP;
                        cyc_val = GAP_LD;
                    end
                end
            end
            GAP: begin
                if (bus.abort && !ab_flag) begin
                    ab_flag_n = 1'b1;
                    abp_n     = 1'b1;
                end
                if (cyc_zero) begin
                    if (ab_flag || bus.abort) begin
                        state_n = IDLE;
                    end else if (bst_zero) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end else begin
                        state_n  = RUN_A;
                        cyc_load = 1'b1;
                        cyc_val  = RA_LD;
                        bst_dec  = 1'b1;
                        idx_inc  = 1'b1;
                    end
                end
            end
        endcase
    end

    // Registered outputs derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.a_out     <= 1'b0;
            bus.b_out     <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.aborted   <= 1'b0;
            bus.burst_idx <= '0;
        end else begin
            bus.a_out   <= (state_n == RUN_A) || (state_n == RUN_AB);
            bus.b_out   <= (state_n == RUN_AB);
            bus.busy    <= (state_n != IDLE);
            bus.done    <= done_n;
            bus.aborted <= abp_n;
            if (idx_clr) begin
                bus.burst_idx <= '0;
            end else if (idx_inc) begin
                bus.burst_idx <= bus.burst_idx + BURST_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_ab_burst_sequencer.sv
// Self-checking bench for ab_burst_sequencer: vector table,
// hand-written corner sequences and a randomized reference model.
module tb_ab_burst_sequencer;
    import ab_seq_pkg::*;

    localparam int AL  = A_LEN_DEF;
    localparam int BA  = B_AFTER_DEF;
    localparam int GL  = GAP_LEN_DEF;
    localparam int BW  = 4;
    localparam int PER = AL + GL;
    localparam int T1  = 9;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    ab_burst_sequencer_if #(.BURST_W(BW)) bus ();

    ab_burst_sequencer #(
        .A_LEN   (AL),
        .B_AFTER (BA),
        .GAP_LEN (GL),
        .BURST_W (BW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: position within the burst period.
    bit m_busy, m_kill;
    int m_p, m_burst, m_n;
    bit e_done, e_ab;

    typedef struct {
        bit         st;
        bit         ab;
        logic [3:0] n;
        logic [4:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic void m_reset();
        m_busy  = 0;
        m_kill  = 0;
        m_p     = 0;
        m_burst = 0;
        m_n     = 1;
        e_done  = 0;
        e_ab    = 0;
    endfunction

    function automatic void m_edge(bit st, bit ab, int n);
        e_done = 0;
        e_ab   = 0;
        if (!m_busy) begin
            if (st && !ab) begin
                m_busy  = 1;
                m_n     = (n == 0) ? 1 : n;
                m_burst = 0;
                m_p     = 0;
                m_kill  = 0;
            end
        end else begin
            if (ab && !m_kill) begin
                e_ab   = 1;
                m_kill = 1;
                if (m_p < AL) m_p = AL - 1;
            end
            m_p++;
            if (m_p == PER) begin
                m_p = 0;
                if (m_kill) begin
                    m_busy = 0;
                end else if (m_burst == m_n - 1) begin
                    m_busy = 0;
                    e_done = 1;
                end else begin
                    m_burst++;
                end
            end
        end
    endfunction

    function automatic logic [8:0] m_exp();
        logic a, b;
        logic [3:0] idx;
        a   = m_busy && (m_p < AL);
        b   = m_busy && (m_p >= BA) && (m_p < AL);
        idx = m_busy ? 4'(m_burst) : 4'd0;
        return {a, b, m_busy, e_done, e_ab, idx};
    endfunction

    function automatic logic [8:0] dut_vec();
        logic [3:0] idx;
        idx = m_busy ? bus.burst_idx : 4'd0;
        return {bus.a_out, bus.b_out, bus.busy,
                bus.done, bus.aborted, idx};
    endfunction

    function automatic logic [4:0] dut_out();
        return {bus.a_out, bus.b_out, bus.busy, bus.done, bus.aborted};
    endfunction

    task automatic check(input string name, input logic [8:0] act,
                         input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%b exp=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit st, input bit ab, input logic [3:0] n);
        bus.start    = st;
        bus.abort    = ab;
        bus.n_bursts = n;
        @(posedge clk);
        m_edge(st, ab, int'(n));
        #1;
        check("model", dut_vec(), m_exp());
    endtask

    task automatic run_row(input int i);
        step(tbl[i].st, tbl[i].ab, tbl[i].n);
        check($sformatf("vec%0d", i), {dut_out(), 4'd0}, {tbl[i].exp, 4'd0});
    endtask

    task automatic run_seq(input logic [3:0] n, input bit hold,
                           output int bcnt, output int dlat);
        bcnt = 0;
        dlat = 0;
        step(1'b1, 1'b0, n);
        for (int i = 0; i < 200; i++) begin
            if (bus.busy) bcnt++;
            if (bus.done) begin
                dlat = i + 1;
                break;
            end
            step(hold, 1'b0, n);
        end
    endtask

    function automatic void add(bit st, bit ab, logic [3:0] n,
                                logic [4:0] exp);
        vec_t v;
        v.st  = st;
        v.ab  = ab;
        v.n   = n;
        v.exp = exp;
        tbl.push_back(v);
    endfunction

    initial begin
        int bc, dl, guard, nb;

        // {a, b, busy, done, aborted}
        add(1, 0, 1, 5'b10100);
        add(0, 0, 1, 5'b10100);
        add(0, 0, 1, 5'b10100);
        add(0, 0, 1, 5'b10100);
        add(0, 0, 1, 5'b11100);
        add(0, 0, 1, 5'b00100);
        add(0, 0, 1, 5'b00100);
        add(0, 0, 1, 5'b00010);
        add(0, 0, 1, 5'b00000);
        add(1, 1, 1, 5'b00000);
        add(1, 1, 2, 5'b00000);
        add(1, 0, 1, 5'b10100);
        add(0, 0, 1, 5'b10100);
        add(0, 0, 1, 5'b10100);
        add(0, 1, 1, 5'b00101);
        add(0, 0, 1, 5'b00100);
        add(0, 0, 1, 5'b00000);
        add(0, 0, 1, 5'b00000);
        add(0, 1, 0, 5'b00000);

        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.n_bursts = '0;
        m_reset();

        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", dut_vec(), 9'd0);
        rst_n = 1'b1;

        repeat (9) step(1'b0, 1'b0, 4'd0);
        for (int i = 0; i < tbl.size(); i++) run_row(i);

        run_seq(4'd3, 1'b0, bc, dl);
        check("n3_busy", 9'(bc), 9'(3 * PER));
        check("n3_done", 9'(dl), 9'(3 * PER + 1));
        repeat (3) step(1'b0, 1'b0, 4'd3);

        run_seq(4'd0, 1'b0, bc, dl);
        check("n0_busy", 9'(bc), 9'(PER));
        check("n0_done", 9'(dl), 9'(PER + 1));
        repeat (2) step(1'b0, 1'b0, 4'd0);

        run_seq(4'd1, 1'b1, bc, dl);
        check("hold_busy", 9'(bc), 9'(PER));
        check("hold_done", 9'(dl), 9'(PER + 1));
        repeat (3) step(1'b0, 1'b0, 4'd2);

        step(1'b1, 1'b0, 4'd1);
        repeat (4) step(1'b0, 1'b0, 4'd1);
        check("pre_rst_ab", {dut_out(), 4'd0}, {5'b11100, 4'd0});
        #3 rst_n = 1'b0;
        #1;
        check("rst_async", {dut_out(), bus.burst_idx}, 9'd0);
        m_reset();
        bus.start = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < T1; i++) run_row(i);

        for (int s = 0; s < 100; s++) begin
            repeat ($urandom_range(0, 3))
                step(1'b0, $urandom_range(0, 3) == 0, 4'($urandom_range(0, 4)));
            nb = $urandom_range(0, 4);
            step(1'b1, 1'b0, 4'(nb));
            guard = 0;
            while (m_busy && guard < 200) begin
                step($urandom_range(0, 1) == 1,
                     $urandom_range(0, 39) == 0,
                     4'($urandom_range(0, 4)));
                guard++;
            end
            if (guard >= 200) begin
                checks++;
                failures++;
                $display("FAIL rand_timeout seq=%0d busy=%0b exp_idle=1",
                         s, bus.busy);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
